// File: rtl/im_fetch_ctrl.sv
// Instruction-memory fetch sequencer: owns the PC, issues IM reads, buffers returned words with their PC
// and hands them to decode over valid/ready. Define FETCH_PERF_EN to add fetch/stall performance counters.
module im_fetch_ctrl #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 32,
  parameter int                BUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              im_read,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [DATA_W-1:0] im_data,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int                PTR_W     = $clog2(BUF_DEPTH);
  localparam int                CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(BUF_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  entry_t            buf_mem [BUF_DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] pc_q, inflight_pc_q;
  logic              inflight_q, kill_q;

  logic              pop, pop_eff, push;
  logic [CNT_W:0]    occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop     = if_valid & if_ready;
  assign pop_eff = pop & ~redirect;
  // A killed response belongs to the flushed stream and must never enter the buffer.
  assign push    = inflight_q & ~kill_q;

  // Slots already committed (buffered plus in flight) after this cycle's pop; a new read
  // is only issued when its response is guaranteed a free slot, so the buffer cannot overflow.
  assign occupancy = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
  assign im_read   = ~rst & ~halt & ~redirect & (occupancy < DEPTH_EXT);
  assign im_addr   = pc_q;

  assign head     = buf_mem[rd_ptr_q];
  assign if_valid = (cnt_q != '0);
  assign if_inst  = if_valid ? head.inst : '0;
  assign if_pc    = if_valid ? head.pc   : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
    end else if (redirect) begin
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
      kill_q     <= inflight_q;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      kill_q     <= 1'b0;
      inflight_q <= im_read;
      if (im_read) begin
        pc_q          <= pc_q + ADDR_W'(1);
        inflight_pc_q <= pc_q;
      end
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_eff) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop_eff})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: the buffer storage is deliberately not reset; cnt_q gates every read of it,
  // so stale contents are never observable and the array can map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (!rst && !redirect && push) begin
      buf_mem[wr_ptr_q] <= '{pc: inflight_pc_q, inst: im_data};
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters; only rst clears them, redirects leave them running.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop_eff && (perf_fetch_cnt != '1)) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (if_ready && !if_valid && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  // Performance counters are absent in this build.
`endif

endmodule
